executs32_stage: RTL and testbench

//  EX stage of the Minisys-1A 5-stage pipelined 32-bit MIPS CPU. Performs ALU, shift, compare,

---
 rtl/executs32_stage.sv | 130 +++++++++++++
 tb/tb_executs32_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/executs32_stage.sv
// executs32_stage: Minisys-1A EX stage with forwarding, ALU/shift/compare, mult/div and HI/LO.
module executs32_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] PC_plus_4,
   input  logic [31:0] Read_data_1,
   input  logic [31:0] Read_data_2,
   input  logic [1:0]  ALUOp,
   input  logic [31:0] Sign_extend,
   input  logic [5:0]  Func,
   input  logic [5:0]  Op,
   input  logic [4:0]  Shamt,
   input  logic [4:0]  address0,
   input  logic [4:0]  address1,
   input  logic        Sftmd,
   input  logic        DivSel,
   input  logic        ALUSrc,
   input  logic [1:0]  ALUSrcA,
   input  logic [1:0]  ALUSrcB,
   input  logic        I_format,
   input  logic        Jrn,
   input  logic        RegDst,
   input  logic        Mfhi,
   input  logic        Mflo,
   input  logic        Mthi,
   input  logic        Mtlo,
   input  logic [31:0] EX_MEM_ALU_result,
   input  logic [31:0] WB_data,
   output logic        Zero,
   output logic        Positive,
   output logic        Negative,
   output logic        Overflow,
   output logic        Divide_zero,
   output logic [4:0]  address,
   output logic [31:0] ALU_Result,
   output logic [31:0] rt_value,
   output logic [4:0]  rd,
   output logic [31:0] Add_Result
);
   logic [31:0] a, rtf, imm, b, sum, dif, r_res, i_res, hi_q, lo_q, hi_d, lo_d;
   logic signed [31:0] qs, rs;
   logic [63:0] prod_s, prod_u;
   logic [4:0] sa;
   logic rtype, is_mult, is_div, ovf_add, ovf_sub;
   always_comb begin
      a = (ALUSrcA == 2'd1) ? EX_MEM_ALU_result : (ALUSrcA == 2'd2) ? WB_data : Read_data_1;
      rtf = (ALUSrcB == 2'd1) ? EX_MEM_ALU_result : (ALUSrcB == 2'd2) ? WB_data : Read_data_2;
      imm = (Op == 6'h0C || Op == 6'h0D || Op == 6'h0E) ? {16'b0, Sign_extend[15:0]} : Sign_extend;
      b = ALUSrc ? imm : rtf;
      sum = a + b;
      dif = a - b;
      sa = Func[2] ? a[4:0] : Shamt;
      ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
      ovf_sub = (a[31] != b[31]) && (dif[31] != a[31]);
   end
   always_comb begin
      r_res = 32'd0;
      case (Func)
         6'h00, 6'h04: r_res = Sftmd ? rtf << sa : 32'd0;
         6'h02, 6'h06: r_res = Sftmd ? rtf >> sa : 32'd0;
         6'h03, 6'h07: r_res = Sftmd ? $unsigned($signed(rtf) >>> sa) : 32'd0;
         6'h09:        r_res = Jrn ? PC_plus_4 : 32'd0;
         6'h10:        r_res = hi_q;
         6'h12:        r_res = lo_q;
         6'h20, 6'h21: r_res = sum;
         6'h22, 6'h23: r_res = dif;
         6'h24:        r_res = a & b;
         6'h25:        r_res = a | b;
         6'h26:        r_res = a ^ b;
         6'h27:        r_res = ~(a | b);
         6'h2A:        r_res = {31'd0, $signed(a) < $signed(b)};
         6'h2B:        r_res = {31'd0, a < b};
         default:      r_res = 32'd0;
      endcase
   end
   always_comb begin
      i_res = 32'd0;
      case (Op)
         6'h08, 6'h09: i_res = sum;
         6'h0A:        i_res = {31'd0, $signed(a) < $signed(b)};
         6'h0B:        i_res = {31'd0, a < b};
         6'h0C:        i_res = a & b;
         6'h0D:        i_res = a | b;
         6'h0E:        i_res = a ^ b;
         6'h0F:        i_res = {imm[15:0], 16'd0};
         default:      i_res = 32'd0;
      endcase
   end
   always_comb begin
      rtype = ALUOp[1] && !I_format;
      is_mult = rtype && (Func == 6'h18 || Func == 6'h19);
      is_div = rtype && DivSel && (Func == 6'h1A || Func == 6'h1B);
      ALU_Result = Mfhi ? hi_q : Mflo ? lo_q : (ALUOp == 2'b00) ? sum :
                   (ALUOp == 2'b01) ? dif : I_format ? i_res : r_res;
      Zero = (ALU_Result == 32'd0);
      Overflow = ALUOp[1] && (I_format ? (Op == 6'h08 && ovf_add) :
                 (Func == 6'h20) ? ovf_add : (Func == 6'h22) ? ovf_sub : 1'b0);
      Divide_zero = is_div && (rtf == 32'd0);
      Positive = !a[31] && (a != 32'd0);
      Negative = a[31];
      address = RegDst ? address1 : address0;
      rd = address1;
      rt_value = rtf;
      Add_Result = PC_plus_4 + Sign_extend;
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{rtf[31]}}, rtf});
      prod_u = {32'd0, a} * {32'd0, rtf};
      qs = $signed(a) / $signed(rtf);
      rs = $signed(a) % $signed(rtf);
   end
   // Mult/div results take precedence over mthi/mtlo; a zero divisor leaves HI/LO alone.
   always_comb begin
      hi_d = Mthi ? a : hi_q;
      lo_d = Mtlo ? a : lo_q;
      if (is_mult)
         {hi_d, lo_d} = Func[0] ? prod_u : prod_s;
      else if (is_div && rtf != 32'd0) begin
         lo_d = Func[0] ? a / rtf : $unsigned(qs);
         hi_d = Func[0] ? a % rtf : $unsigned(rs);
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
endmodule

// File: tb/tb_executs32_stage.sv
// tb_executs32_stage: directed scoreboard bench for the EX stage datapath and HI/LO state.
module tb_executs32_stage;
   logic clock = 0, reset;
   logic [31:0] PC_plus_4, Read_data_1, Read_data_2, Sign_extend, EX_MEM_ALU_result, WB_data;
   logic [1:0] ALUOp, ALUSrcA, ALUSrcB;
   logic [5:0] Func, Op;
   logic [4:0] Shamt, address0, address1;
   logic Sftmd, DivSel, ALUSrc, I_format, Jrn, RegDst, Mfhi, Mflo, Mthi, Mtlo;
   logic Zero, Positive, Negative, Overflow, Divide_zero;
   logic [4:0] address, rd;
   logic [31:0] ALU_Result, rt_value, Add_Result;
   typedef struct {string tag; int sel; logic [31:0] v;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   always #5 clock = ~clock;
   executs32_stage dut (
      .clock(clock), .reset(reset), .PC_plus_4(PC_plus_4), .Read_data_1(Read_data_1),
      .Read_data_2(Read_data_2), .ALUOp(ALUOp), .Sign_extend(Sign_extend), .Func(Func), .Op(Op),
      .Shamt(Shamt), .address0(address0), .address1(address1), .Sftmd(Sftmd), .DivSel(DivSel),
      .ALUSrc(ALUSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .I_format(I_format), .Jrn(Jrn),
      .RegDst(RegDst), .Mfhi(Mfhi), .Mflo(Mflo), .Mthi(Mthi), .Mtlo(Mtlo),
      .EX_MEM_ALU_result(EX_MEM_ALU_result), .WB_data(WB_data), .Zero(Zero), .Positive(Positive),
      .Negative(Negative), .Overflow(Overflow), .Divide_zero(Divide_zero), .address(address),
      .ALU_Result(ALU_Result), .rt_value(rt_value), .rd(rd), .Add_Result(Add_Result));
   localparam int RES = 0, ZER = 1, OVF = 2, DZ = 3, ADR = 4, ADD = 5, RTV = 6, POS = 7, NEG = 8, RD = 9;
   function automatic logic [31:0] obs(int s);
      case (s)
         RES: return ALU_Result;
         ZER: return {31'd0, Zero};
         OVF: return {31'd0, Overflow};
         DZ:  return {31'd0, Divide_zero};
         ADR: return {27'd0, address};
         ADD: return Add_Result;
         RTV: return rt_value;
         POS: return {31'd0, Positive};
         NEG: return {31'd0, Negative};
         default: return {27'd0, rd};
      endcase
   endfunction
   task automatic want(input string t, input int s, input logic [31:0] v);
      sb.push_back('{t, s, v});
   endtask
   task automatic drain();
      exp_t e;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.sel);
         checks++;
         assert (o === e.v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, o, e.v);
         end
      end
   endtask
   task automatic clr();
      @(negedge clock);
      reset = 0; PC_plus_4 = 0; Read_data_1 = 0; Read_data_2 = 0; Sign_extend = 0;
      EX_MEM_ALU_result = 0; WB_data = 0; ALUOp = 0; ALUSrcA = 0; ALUSrcB = 0; Func = 0; Op = 0;
      Shamt = 0; address0 = 0; address1 = 0; Sftmd = 0; DivSel = 0; ALUSrc = 0; I_format = 0;
      Jrn = 0; RegDst = 0; Mfhi = 0; Mflo = 0; Mthi = 0; Mtlo = 0;
   endtask
   task automatic rtyp(input logic [5:0] f, input logic [31:0] ra, input logic [31:0] rb);
      clr(); ALUOp = 2'b10; Func = f; Read_data_1 = ra; Read_data_2 = rb;
   endtask
   task automatic hilo(input string t, input logic [31:0] h, input logic [31:0] l);
      clr(); Mfhi = 1; want({t, "_hi"}, RES, h); drain();
      clr(); Mflo = 1; want({t, "_lo"}, RES, l); drain();
   endtask
   initial begin
      clr(); reset = 1; Mthi = 1; Read_data_1 = 32'h1111;
      clr(); reset = 1;
      want("reset_zero", ZER, 1); want("reset_res", RES, 0); drain();
      hilo("reset", 0, 0);
      clr(); Op = 6'h0F; ALUOp = 2'b10; I_format = 1; ALUSrc = 1; Sign_extend = 32'hFFFFFFFF;
      address0 = 5'd7; address1 = 5'd9;
      want("lui_res", RES, 32'hFFFF0000); want("lui_addr", ADR, 7); want("lui_rd", RD, 9); drain();
      clr(); Op = 6'h09; ALUOp = 2'b10; I_format = 1; ALUSrc = 1; ALUSrcA = 2; WB_data = 0;
      Read_data_1 = 32'h1234; Sign_extend = 32'h3D;
      want("addiu_fwd", RES, 32'h3D); want("addiu_ovf", OVF, 0); drain();
      clr(); Op = 6'h0C; ALUOp = 2'b10; I_format = 1; ALUSrc = 1; Read_data_1 = 5; Sign_extend = 2;
      want("andi_res", RES, 0); want("andi_zero", ZER, 1); drain();
      clr(); Op = 6'h0D; ALUOp = 2'b10; I_format = 1; ALUSrc = 1; Sign_extend = 32'hFFFF8001;
      want("ori_zext", RES, 32'h00008001); drain();
      rtyp(6'h18, 0, 0); ALUSrcA = 1; EX_MEM_ALU_result = 32'hFFFF0000; ALUSrcB = 2; WB_data = 32'h3D;
      want("mult_rtv", RTV, 32'h3D); drain();
      hilo("mult", 32'hFFFFFFFF, 32'hFFC30000);
      rtyp(6'h19, 32'hFFFF0000, 32'h3D); drain();
      hilo("multu", 32'h3C, 32'hFFC30000);
      rtyp(6'h00, 0, 1); Shamt = 6; Sftmd = 1; RegDst = 1; address0 = 5'd3; address1 = 5'h1F;
      want("sll_res", RES, 32'h40); want("sll_addr", ADR, 5'h1F); drain();
      rtyp(6'h07, 4, 32'h80000000); Sftmd = 1;
      want("srav", RES, 32'hF8000000); drain();
      rtyp(6'h02, 0, 32'h80000000); Sftmd = 1; Shamt = 4;
      want("srl", RES, 32'h08000000); drain();
      clr(); ALUOp = 2'b01; Read_data_1 = 5; Read_data_2 = 5; PC_plus_4 = 6; Sign_extend = 32'hFFFFFFFF;
      want("beq_zero", ZER, 1); want("beq_target", ADD, 5); drain();
      rtyp(6'h20, 32'h7FFFFFFF, 1);
      want("add_res", RES, 32'h80000000); want("add_ovf", OVF, 1); want("add_pos", POS, 1);
      want("add_neg", NEG, 0); drain();
      rtyp(6'h21, 32'h7FFFFFFF, 1);
      want("addu_ovf", OVF, 0); drain();
      rtyp(6'h22, 32'h80000000, 1);
      want("sub_res", RES, 32'h7FFFFFFF); want("sub_ovf", OVF, 1); want("sub_neg", NEG, 1); drain();
      rtyp(6'h2A, 32'hFFFFFFFF, 1); want("slt", RES, 1); drain();
      rtyp(6'h2B, 32'hFFFFFFFF, 1); want("sltu", RES, 0); drain();
      rtyp(6'h27, 0, 0); want("nor", RES, 32'hFFFFFFFF); drain();
      rtyp(6'h09, 0, 0); Jrn = 1; PC_plus_4 = 32'h100; want("jalr_link", RES, 32'h100); drain();
      clr(); Mthi = 1; Read_data_1 = 32'hAAAA;
      clr(); Mtlo = 1; Read_data_1 = 32'h5555;
      rtyp(6'h1A, 7, 0); DivSel = 1; want("div0_flag", DZ, 1); drain();
      hilo("div0_kept", 32'hAAAA, 32'h5555);
      rtyp(6'h1A, 32'hFFFFFFF9, 2); DivSel = 1; want("div_flag", DZ, 0); drain();
      hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
      rtyp(6'h1B, 32'hFFFFFFF9, 2); DivSel = 1; drain();
      hilo("divu", 1, 32'h7FFFFFFC);
      rtyp(6'h19, 3, 5); Mthi = 1; Mtlo = 1; drain();
      hilo("mult_prio", 0, 32'hF);
      rtyp(6'h18, 32'hFFFF0000, 32'h3D); reset = 1; drain();
      hilo("reset_mult", 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
